// File: rtl/pipe_stage_chain.sv
// Elastic valid/ready register chain of STAGES slots with per-slot kill, flush and bubble collapsing.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt performance counters.

module pipe_stage_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              loadValid,
  input  logic              holdValid,
  input  logic [DATA_W-1:0] loadData,
  output logic              validNext,
  output logic              validQ,
  output logic [DATA_W-1:0] dataQ
);
  assign validNext = rst_n & (load ? loadValid : holdValid);

  always_ff @(posedge clk) begin
    if (!rst_n) validQ <= 1'b0;
    else        validQ <= validNext;
  end

  // Payload is only captured when live data arrives; it is never reset.
  always_ff @(posedge clk) begin
    if (load && loadValid) dataQ <= loadData;
  end
endmodule

module pipe_stage_chain #(
  parameter int DATA_W = 32,
  parameter int STAGES = 3,
  parameter int OCC_W  = $clog2(STAGES+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic [STAGES-1:0] kill,
  output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);
  logic [STAGES-1:0]             validQ, validNext, vEff, rdy, loadValid;
  logic [STAGES-1:0][DATA_W-1:0] dataQ, loadData;
  logic [OCC_W-1:0]              occNext;
  logic                          run;

  assign vEff = validQ & ~kill & {STAGES{~flush}};

  // A slot is ready when it or any slot downstream of it is free this cycle.
  always_comb begin
    rdy = '0;
    run = out_ready;
    for (int i = STAGES-1; i >= 0; i--) begin
      run    = run | ~vEff[i];
      rdy[i] = run;
    end
  end

  assign in_ready  = rdy[0] & ~flush & rst_n;
  assign out_valid = vEff[STAGES-1] & rst_n;
  assign out_data  = dataQ[STAGES-1];

  always_comb begin
    loadValid    = '0;
    loadData     = '0;
    loadValid[0] = in_valid & in_ready;
    loadData[0]  = in_data;
    for (int i = 1; i < STAGES; i++) begin
      loadValid[i] = vEff[i-1];
      loadData[i]  = dataQ[i-1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : gSlot
    pipe_stage_slot #(.DATA_W(DATA_W)) uSlot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rdy[i]),
      .loadValid (loadValid[i]),
      .holdValid (vEff[i]),
      .loadData  (loadData[i]),
      .validNext (validNext[i]),
      .validQ    (validQ[i]),
      .dataQ     (dataQ[i])
    );
  end

  always_comb begin
    occNext = '0;
    for (int i = 0; i < STAGES; i++) occNext = occNext + OCC_W'(validNext[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) occupancy <= '0;
    else        occupancy <= occNext;
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (!out_valid && occupancy != '0 && bubble_cnt != 32'hFFFF_FFFF)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif
endmodule
